mdu_hilo: RTL and testbench
===========================

Name: mdu_hilo

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers. Sits beside the ALU in the execute stage.
- Consumes forwarded operands (post-forwarding-mux srca/srcb) plus a decoded op from the ID/EX register.
- Produces HI/LO for the MFHI/MFLO writeback path.
- Drives busy to the hazard unit so it stalls IF/ID/EX while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width. Only 32 is supported.
- CNT_W, 5, iteration counter width; log2(WIDTH).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- start  input  1  request, sampled on rising edge; accepted only when busy=0.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 no-op.
- a  input  32  rs operand (dividend / multiplicand / MTHI/MTLO data).
- b  input  32  rt operand (divisor / multiplier).
- flush  input  1  abort in-flight operation (exception/branch flush).
- busy  output  1  high while an operation is in flight.
- done  output  1  one-cycle pulse when HI/LO update from a mul/div.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - busy=0, done=0, hi=0, lo=0, counter=0.
  - Applies mid-operation too; any in-flight result is discarded.
- FSM states: IDLE, RUN, FIX.
  - busy = (state != IDLE).
  - done is a registered output.
- IDLE:
  - start=1 with op in {MULT, MULTU, DIV, DIVU} at edge E0:
    - Latch |a| and |b| (raw values for the U ops).
    - Latch the sign flags and the raw dividend.
    - counter=0, state=RUN.
  - start=1 with MTHI/MTLO: write a into hi/lo at that edge. State stays IDLE, busy stays 0, done stays 0.
  - op 110/111: ignored.
- RUN: one iteration per edge.
  - Multiply: radix-2 shift-add on a 64-bit accumulator.
  - Divide: restoring shift-subtract; quotient and remainder each 32 bits.
  - At the edge where counter==31, go to FIX; otherwise counter+1.
  - Edges E1..E32.
- FIX (edge E33):
  - Apply sign correction:
    - product negated (64-bit two's complement) if signs differ;
    - quotient negated if signs differ;
    - remainder takes the dividend's sign.
  - Write hi/lo, state=IDLE, done=1 for exactly the cycle following E33.
- Latency and stalls:
  - busy is high in the 33 cycles following E0.
  - hi/lo hold their old values until E33.
  - A new start may be accepted at E33+1.
- start while busy=1: ignored, including MTHI/MTLO. The hazard unit must hold the instruction until busy=0.
- Result mapping:
  - Multiply: hi = product[63:32], lo = product[31:0].
  - Divide: lo = quotient, hi = remainder.
- Divide by zero (b==0): lo=32'hFFFF_FFFF, hi=a (raw dividend); same 33-cycle latency.
- Signed overflow 32'h8000_0000 / 32'hFFFF_FFFF: lo=32'h8000_0000, hi=0.
- flush=1 in RUN or FIX:
  - state=IDLE at that edge; hi/lo unchanged; done stays 0.
  - flush has priority over FIX completion.
  - flush in IDLE: no effect, and any simultaneous start is dropped.
- hi/lo are readable combinationally at all times. No internal forwarding of in-flight results.

Test Plan:
- MULT a=7, b=32'hFFFF_FFFD at E0 -> busy=1 for 33 cycles; at E33 hi=32'hFFFF_FFFF, lo=32'hFFFF_FFEB; done pulses one cycle.
- MULTU a=b=32'hFFFF_FFFF -> hi=32'hFFFF_FFFE, lo=32'h0000_0001; then MTLO a=5 while busy -> ignored, lo unchanged until E33.
- DIV a=32'hFFFF_FFF9 (-7), b=2 -> lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF. DIVU a=100, b=7 -> lo=14, hi=2.
- DIVU a=100, b=0 -> lo=32'hFFFF_FFFF, hi=32'h0000_0064. DIV 32'h8000_0000 / 32'hFFFF_FFFF -> lo=32'h8000_0000, hi=0.
- MTHI a=32'hDEAD_BEEF, then MULT 3*4, flush at cycle 10 -> busy falls next edge; hi=32'hDEAD_BEEF, lo unchanged; done never asserts.
- reset=0 at cycle 20 of a DIV -> busy=0, hi=lo=0 immediately. After release, MULT 2*2 -> lo=4 at E33.

Source files
------------

// File: rtl/mdu_hilo.sv
// Iterative MIPS-style mul/div with HI/LO; 33 cycles from accept to HI/LO update, MTHI/MTLO same-edge.
// No input queueing: start is dropped while busy, so the hazard unit must hold the instruction.
module mdu_hilo #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    localparam logic [2:0] OP_MTHI = 3'b100;
    localparam logic [2:0] OP_MTLO = 3'b101;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     opnd;
    logic [WIDTH-1:0]     raw_a;
    logic                 is_div;
    logic                 neg_res;
    logic                 neg_rem;

    logic                 is_signed;
    logic [WIDTH-1:0]     a_abs;
    logic [WIDTH-1:0]     b_abs;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_tmp;
    logic [WIDTH:0]       div_diff;
    logic                 div_ge;
    logic [WIDTH-1:0]     rem_next;
    logic [2*WIDTH-1:0]   step_next;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quot_fix;
    logic [WIDTH-1:0]     rem_fix;

    assign busy = (state != IDLE);

    always_comb begin
        is_signed = ~op[0];
        a_abs     = (is_signed && a[WIDTH-1]) ? -a : a;
        b_abs     = (is_signed && b[WIDTH-1]) ? -b : b;

        // acc = {partial product, remaining multiplier bits}
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);

        // acc = {remainder, dividend bits shifting into quotient}
        div_tmp   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        div_diff  = div_tmp - {1'b0, opnd};
        div_ge    = ~div_diff[WIDTH];
        rem_next  = div_ge ? div_diff[WIDTH-1:0] : div_tmp[WIDTH-1:0];

        step_next = is_div ? {rem_next, acc[WIDTH-2:0], div_ge}
                           : {mul_sum, acc[WIDTH-1:1]};

        prod_fix  = neg_res ? -acc : acc;
        quot_fix  = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix   = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            acc     <= '0;
            opnd    <= '0;
            raw_a   <= '0;
            is_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !flush) begin
                        if (!op[2]) begin
                            is_div  <= op[1];
                            neg_res <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_rem <= is_signed & a[WIDTH-1];
                            raw_a   <= a;
                            cnt     <= '0;
                            state   <= RUN;
                            if (op[1]) begin
                                opnd <= b_abs;
                                acc  <= {{WIDTH{1'b0}}, a_abs};
                            end else begin
                                opnd <= a_abs;
                                acc  <= {{WIDTH{1'b0}}, b_abs};
                            end
                        end else if (op == OP_MTHI) begin
                            hi <= a;
                        end else if (op == OP_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                RUN: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        acc <= step_next;
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            state <= FIX;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                FIX: begin
                    state <= IDLE;
                    if (!flush) begin
                        done <= 1'b1;
                        if (!is_div) begin
                            hi <= prod_fix[2*WIDTH-1:WIDTH];
                            lo <= prod_fix[WIDTH-1:0];
                        end else if (opnd == '0) begin
                            // divide by zero: all-ones quotient, dividend passes through as remainder
                            hi <= raw_a;
                            lo <= '1;
                        end else begin
                            hi <= rem_fix;
                            lo <= quot_fix;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: expected HI/LO pushed at issue, popped and compared on each done pulse.
module tb_mdu_hilo;
    localparam logic [2:0] MULT  = 3'b000;
    localparam logic [2:0] MULTU = 3'b001;
    localparam logic [2:0] DIV   = 3'b010;
    localparam logic [2:0] DIVU  = 3'b011;
    localparam logic [2:0] MTHI  = 3'b100;
    localparam logic [2:0] MTLO  = 3'b101;

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          errors;
    int          checks;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;
    logic [31:0] model_hi;
    logic [31:0] model_lo;

    mdu_hilo #(.WIDTH(32), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (reset && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 hi=%h lo=%h, required no done", hi, lo);
            end else begin
                mon_exp = exp_q.pop_front();
                check("result_hilo", {hi, lo}, mon_exp);
            end
        end
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        a     = va;
        b     = vb;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] va, input logic [31:0] vb,
                          input logic [31:0] eh, input logic [31:0] el, input bit mtlo_mid);
        int n;
        exp_q.push_back({eh, el});
        issue(o, va, vb);
        n = 0;
        while (busy && n < 100) begin
            if (mtlo_mid && n == 5) begin
                start = 1'b1;
                op    = MTLO;
                a     = 32'd5;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
            if (n == 32) check("hold_hilo", {hi, lo}, {model_hi, model_lo});
        end
        check("busy_cycles", 64'(n), 64'd33);
        model_hi = eh;
        model_lo = el;
    endtask

    task automatic mt(input logic [2:0] o, input logic [31:0] v);
        issue(o, v, 32'd0);
        if (o == MTHI) model_hi = v;
        else           model_lo = v;
        check("mt_hilo", {hi, lo}, {model_hi, model_lo});
        check("mt_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        reset    = 1'b0;
        start    = 1'b0;
        op       = 3'b111;
        a        = '0;
        b        = '0;
        flush    = 1'b0;
        model_hi = '0;
        model_lo = '0;

        #12;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        run_op(MULT,  32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run_op(MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b1);
        run_op(DIV,   32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op(DIVU,  32'd100,        32'd7,         32'd2,         32'd14,        1'b0);
        run_op(DIVU,  32'd100,        32'd0,         32'h0000_0064, 32'hFFFF_FFFF, 1'b0);
        run_op(DIV,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);
        run_op(DIV,   32'd7,          32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0);
        run_op(MULT,  32'h8000_0000,  32'd2,         32'hFFFF_FFFF, 32'h0000_0000, 1'b0);

        mt(MTHI, 32'hDEAD_BEEF);
        mt(MTLO, 32'h1234_5678);

        // Flush mid-multiply: no result, no done
        issue(MULT, 32'd3, 32'd4);
        repeat (8) @(posedge clk);
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", 64'(busy), 64'd0);
        check("flush_hilo", {hi, lo}, {model_hi, model_lo});
        repeat (40) @(posedge clk);
        #1;
        check("flush_after_hilo", {hi, lo}, {model_hi, model_lo});

        // Flush in IDLE drops a simultaneous MTLO
        @(negedge clk);
        flush = 1'b1;
        start = 1'b1;
        op    = MTLO;
        a     = 32'd123;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check("idle_flush_lo", 64'(lo), 64'(model_lo));

        // Asynchronous reset mid-divide
        issue(DIV, 32'd100, 32'd7);
        repeat (19) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        model_hi = '0;
        model_lo = '0;
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_hilo", {hi, lo}, 64'd0);
        check("arst_done", 64'(done), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        run_op(MULT, 32'd2, 32'd2, 32'd0, 32'd4, 1'b0);

        repeat (3) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
